// File: rtl/mtpsa_user_arbiter.sv
// Packet-granular round-robin merge of per-tenant AXIS user pipelines
// into one stream, with per-user enable masking and grant status.
module mtpsa_user_arbiter #(
  parameter int NUM_USERS   = 8,
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 296
) (
  input  logic                              axis_aclk,
  input  logic                              axis_rst,
  input  logic [NUM_USERS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_USERS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_USERS*TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_USERS-1:0]              s_axis_tvalid,
  input  logic [NUM_USERS-1:0]              s_axis_tlast,
  output logic [NUM_USERS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [NUM_USERS-1:0]              user_enable,
  output logic [NUM_USERS-1:0]              arb_grant,
  output logic                              arb_busy
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int IW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  typedef enum logic {
    IDLE,
    PKT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_USERS-1:0] req;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            own_vld;
  logic            own_last;
  logic            own_fire;

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input int            k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_USERS) s = s - NUM_USERS;
    return IW'(s);
  endfunction

  assign req      = s_axis_tvalid & user_enable;
  assign own_vld  = s_axis_tvalid[grant_q];
  assign own_last = s_axis_tlast[grant_q];
  assign own_fire = (state_q == PKT) & own_vld
                  & m_axis_tready & own_last;
  assign arb_busy = (state_q == PKT);

  // First requester at or after rr_ptr, wrapping upward.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_USERS; k++) begin
      if (!pick_vld && req[wrap_add(rr_ptr_q, k)]) begin
        pick     = wrap_add(rr_ptr_q, k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = PKT;
          grant_d = pick;
        end
      end
      PKT: begin
        if (own_fire) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_add(grant_q, 1);
        end
      end
    endcase
  end

  // Outputs are forced to zero whenever nobody owns the stream.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    arb_grant     = '0;
    if (state_q == PKT) begin
      m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KW +: KW];
      m_axis_tuser  = s_axis_tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH];
      m_axis_tvalid = own_vld;
      m_axis_tlast  = own_last;
      s_axis_tready[grant_q] = m_axis_tready;
      arb_grant[grant_q]     = 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
